spi_reg_slave: RTL and testbench

SPI responder and configuration register file for the digital core. It decodes the 0xC1/0xC5/0xC2/0xCA command set issued by the external SPI master on sclk/csn/mosi and holds REGCOUNT 8-bit control registers. It drives miso and exposes the registers as a flat bus to the enable and control decode logic. Everything runs on sys_clk; the SPI pins are oversampled.

---
 rtl/spi_reg_slave.sv | 218 +++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder with a small 8-bit register file, oversampled on sys_clk.
// Decodes single/burst read and write commands and exposes registers as a flat bus.
module spi_reg_slave #(
  parameter int unsigned REGCOUNT    = 14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  por_rst,
  input  logic                  sclk,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  output logic [8*REGCOUNT-1:0] regs,
  output logic                  wr_pulse,
  output logic [7:0]            wr_addr,
  output logic [7:0]            wr_data
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWdata, StRdata, StIgnore} state_e;

  localparam logic [7:0] CmdRd      = 8'hC1;
  localparam logic [7:0] CmdRdBurst = 8'hC5;
  localparam logic [7:0] CmdWr      = 8'hC2;
  localparam logic [7:0] CmdWrBurst = 8'hCA;
  localparam logic [7:0] LastAddr   = 8'(REGCOUNT - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q;
  logic                   sclk_s, csn_s, mosi_s, rise, fall;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] shreg_q, shreg_d;
  logic       load_pend_q, load_pend_d;
  logic       seen_q, seen_d;
  logic [7:0] regs_q [REGCOUNT];
  logic [7:0] regs_d [REGCOUNT];
  logic       wr_pulse_q, wr_pulse_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       in_range;
  logic [7:0] ptr_next;
  logic [7:0] rd_val;
  logic       cmd_is_write;
  logic       cmd_valid;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
  assign csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], csn};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_dly_q;
  assign fall   = ~sclk_s & sclk_dly_q;

  assign rx_byte      = {rx_q, mosi_s};
  assign byte_done    = rise && (bit_cnt_q == 3'd7);
  assign in_range     = 32'(ptr_q) < REGCOUNT;
  assign ptr_next     = (ptr_q == LastAddr) ? 8'd0 : ptr_q + 8'd1;
  assign cmd_is_write = (cmd_q == CmdWr) || (cmd_q == CmdWrBurst);
  assign cmd_valid    = (rx_byte == CmdWr) || (rx_byte == CmdWrBurst) ||
                        (rx_byte == CmdRd) || (rx_byte == CmdRdBurst);

  // Out-of-range pointers match no register and read back as zero.
  always_comb begin
    rd_val = 8'h00;
    for (int unsigned k = 0; k < REGCOUNT; k++) begin
      if (ptr_q == 8'(k)) rd_val = regs_q[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    cmd_d       = cmd_q;
    ptr_d       = ptr_q;
    shreg_d     = shreg_q;
    load_pend_d = load_pend_q;
    seen_d      = seen_q | csn_s;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    // csn high takes priority over any sclk edge seen in the same cycle.
    if (csn_s) begin
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      load_pend_d = 1'b0;
    end else begin
      if (state_q != StIdle && rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = rx_byte[6:0];
      end
      unique case (state_q)
        StIdle: begin
          if (seen_q) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
          end
        end
        StCmd: begin
          if (byte_done) begin
            cmd_d   = rx_byte;
            state_d = cmd_valid ? StAddr : StIgnore;
          end
        end
        StAddr: begin
          if (byte_done) begin
            ptr_d = rx_byte;
            if (cmd_is_write) begin
              state_d = StWdata;
            end else begin
              state_d     = StRdata;
              shreg_d     = 8'h00;
              load_pend_d = 1'b1;
            end
          end
        end
        StWdata: begin
          if (byte_done) begin
            if (in_range) begin
              for (int unsigned k = 0; k < REGCOUNT; k++) begin
                if (ptr_q == 8'(k)) regs_d[k] = rx_byte;
              end
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
            end
            if (cmd_q == CmdWr) state_d = StIgnore;
            else                ptr_d   = ptr_next;
          end
        end
        StRdata: begin
          if (fall) begin
            if (load_pend_q) begin
              shreg_d     = rd_val;
              load_pend_d = 1'b0;
            end else begin
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end
          if (byte_done) begin
            if (cmd_q == CmdRd) begin
              state_d = StIgnore;
            end else begin
              ptr_d       = ptr_next;
              load_pend_d = 1'b1;
            end
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (por_rst) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      cmd_q       <= 8'h00;
      ptr_q       <= 8'h00;
      shreg_q     <= 8'h00;
      load_pend_q <= 1'b0;
      seen_q      <= 1'b0;
      regs_q      <= '{default: 8'h00};
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      cmd_q       <= cmd_d;
      ptr_q       <= ptr_d;
      shreg_q     <= shreg_d;
      load_pend_q <= load_pend_d;
      seen_q      <= seen_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned k = 0; k < REGCOUNT; k++) begin
      regs[8*k +: 8] = regs_q[k];
    end
  end

  assign miso     = (state_q == StRdata) & shreg_q[7];
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: frame-level register model plus a per-cycle compare process,
// with literal expectations from the directed test sequence.
module tb_spi_reg_slave;
  localparam int unsigned RC = 14;

  logic            sys_clk = 1'b0;
  logic            por_rst;
  logic            sclk;
  logic            csn;
  logic            mosi;
  logic            miso;
  logic [8*RC-1:0] regs;
  logic            wr_pulse;
  logic [7:0]      wr_addr;
  logic [7:0]      wr_data;

  spi_reg_slave #(.REGCOUNT(RC), .SYNC_STAGES(2)) dut (
    .sys_clk  (sys_clk),
    .por_rst  (por_rst),
    .sclk     (sclk),
    .csn      (csn),
    .mosi     (mosi),
    .miso     (miso),
    .regs     (regs),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl_regs [RC];
  logic [15:0] exp_wr [$];
  bit          model_seen;
  logic [7:0]  tx [8];
  logic [7:0]  rx [8];
  logic        exp_miso [64];
  logic        miso_win = 1'b0;
  logic        miso_exp = 1'b0;
  int          pulse_cnt = 0;
  int          idle_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] adv(input logic [7:0] p);
    return (p == 8'(RC - 1)) ? 8'd0 : p + 8'd1;
  endfunction

  // Frame semantics: which bytes commit and which bits must appear on miso.
  task automatic model_frame(input int nbits, input bit ignore);
    logic [7:0] cmd, ptr, val;
    int base;
    for (int i = 0; i < 64; i++) exp_miso[i] = 1'b0;
    cmd = tx[0];
    ptr = tx[1];
    if (ignore || !model_seen || nbits < 16) return;
    for (int d = 0; d < 6; d++) begin
      base = 16 + 8 * d;
      if (cmd == 8'hC2 || cmd == 8'hCA) begin
        if (base + 8 > nbits) break;
        if (ptr < 8'(RC)) begin
          mdl_regs[ptr] = tx[2 + d];
          exp_wr.push_back({ptr, tx[2 + d]});
        end
        if (cmd == 8'hC2) break;
        ptr = adv(ptr);
      end else if (cmd == 8'hC1 || cmd == 8'hC5) begin
        if (base >= nbits) break;
        val = (ptr < 8'(RC)) ? mdl_regs[ptr] : 8'h00;
        for (int k = 0; k < 8; k++) if (base + k < nbits) exp_miso[base + k] = val[7 - k];
        if (cmd == 8'hC1) break;
        ptr = adv(ptr);
      end else begin
        break;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < RC; k++) mdl_regs[k] = 8'h00;
    exp_wr.delete();
    model_seen = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_wr_pulse"}, 32'(wr_pulse), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'h00);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'h00);
    checks++;
    if (regs !== '0) begin
      errors++;
      $display("FAIL %s_regs: got 0x%h, expected all zero", tag, regs);
    end
  endtask

  task automatic do_reset();
    por_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    por_rst = 1'b0;
    model_reset();
  endtask

  // rst_bit >= 0 pulses por_rst while that bit is on mosi; the frame is then void.
  task automatic spi_frame(input int nbits, input int rst_bit);
    model_frame(nbits, rst_bit >= 0);
    csn = 1'b0;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[i / 8][7 - (i % 8)];
      if (i == rst_bit) begin
        do_reset();
        check_reset_vals("midframe_rst");
      end
      repeat (5) @(negedge sys_clk);
      miso_exp = exp_miso[i];
      miso_win = 1'b1;
      repeat (3) @(negedge sys_clk);
      miso_win = 1'b0;
      rx[i / 8][7 - (i % 8)] = miso;
      sclk = 1'b1;
      repeat (8) @(negedge sys_clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge sys_clk);
    csn = 1'b1;
    repeat (12) @(negedge sys_clk);
    model_seen = 1'b1;
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
    tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3; tx[4] = b4;
    for (int j = 5; j < 8; j++) tx[j] = 8'h00;
  endtask

  // Per-cycle compare against the model.
  always @(negedge sys_clk) begin
    logic [8*RC-1:0] flat;
    logic [15:0] e;
    if (!por_rst) begin
      if (miso_win) chk("miso_bit", 32'(miso), 32'(miso_exp));
      if (wr_pulse) begin
        pulse_cnt++;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_pulse_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                   wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e[15:8]));
          chk("wr_data", 32'(wr_data), 32'(e[7:0]));
          chk("wr_reg", 32'(regs[8*e[15:8] +: 8]), 32'(e[7:0]));
        end
      end
      idle_cnt = csn ? idle_cnt + 1 : 0;
      if (idle_cnt >= 4) begin
        for (int k = 0; k < RC; k++) flat[8*k +: 8] = mdl_regs[k];
        chk("idle_miso", 32'(miso), 32'd0);
        checks++;
        if (regs !== flat) begin
          errors++;
          $display("FAIL idle_regs: got 0x%h, expected 0x%h", regs, flat);
        end
      end
    end else begin
      idle_cnt = 0;
    end
  end

  initial begin
    int p0;
    csn = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    model_reset();
    do_reset();
    check_reset_vals("por");
    repeat (10) @(negedge sys_clk);
    model_seen = 1'b1;

    // Single write then read back.
    p0 = pulse_cnt;
    set_tx(8'hC2, 8'h00, 8'h5A, 8'h00, 8'h00);
    spi_frame(24, -1);
    chk("wr1_reg0", 32'(regs[7:0]), 32'h5A);
    chk("wr1_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("wr1_wr_addr", 32'(wr_addr), 32'h00);
    chk("wr1_wr_data", 32'(wr_data), 32'h5A);
    set_tx(8'hC1, 8'h00, 8'h00, 8'h00, 8'h00);
    spi_frame(24, -1);
    chk("rd1_byte", 32'(rx[2]), 32'h5A);

    // Burst write across the wrap point, then burst read.
    p0 = pulse_cnt;
    set_tx(8'hCA, 8'h0C, 8'h11, 8'h22, 8'h33);
    spi_frame(40, -1);
    chk("bw_reg12", 32'(regs[8*12 +: 8]), 32'h11);
    chk("bw_reg13", 32'(regs[8*13 +: 8]), 32'h22);
    chk("bw_reg0", 32'(regs[7:0]), 32'h33);
    chk("bw_pulses", 32'(pulse_cnt - p0), 32'd3);
    set_tx(8'hC5, 8'h0C, 8'h00, 8'h00, 8'h00);
    spi_frame(40, -1);
    chk("br_byte0", 32'(rx[2]), 32'h11);
    chk("br_byte1", 32'(rx[3]), 32'h22);
    chk("br_byte2", 32'(rx[4]), 32'h33);

    // Out-of-range address.
    p0 = pulse_cnt;
    set_tx(8'hC2, 8'h14, 8'hFF, 8'h00, 8'h00);
    spi_frame(24, -1);
    chk("oor_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("oor_reg0", 32'(regs[7:0]), 32'h33);
    set_tx(8'hC1, 8'h14, 8'h00, 8'h00, 8'h00);
    spi_frame(24, -1);
    chk("oor_rd", 32'(rx[2]), 32'h00);

    // Abort mid-byte and an unknown command.
    p0 = pulse_cnt;
    set_tx(8'hC2, 8'h03, 8'hFF, 8'h00, 8'h00);
    spi_frame(21, -1);
    chk("abort_reg3", 32'(regs[8*3 +: 8]), 32'h00);
    set_tx(8'h55, 8'h03, 8'hAA, 8'h00, 8'h00);
    spi_frame(24, -1);
    chk("unk_reg3", 32'(regs[8*3 +: 8]), 32'h00);
    chk("abort_unk_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Reset during the data byte; rest of frame ignored; next frame works.
    p0 = pulse_cnt;
    set_tx(8'hC2, 8'h01, 8'h77, 8'h00, 8'h00);
    spi_frame(24, 20);
    chk("rstmid_reg1", 32'(regs[15:8]), 32'h00);
    chk("rstmid_pulses", 32'(pulse_cnt - p0), 32'd0);
    spi_frame(24, -1);
    chk("after_rst_reg1", 32'(regs[15:8]), 32'h77);
    chk("after_rst_pulses", 32'(pulse_cnt - p0), 32'd1);

    // csn already low when reset releases: frame ignored.
    p0 = pulse_cnt;
    csn = 1'b0;
    repeat (4) @(negedge sys_clk);
    do_reset();
    set_tx(8'hC2, 8'h02, 8'h99, 8'h00, 8'h00);
    spi_frame(24, -1);
    chk("lowcsn_reg2", 32'(regs[8*2 +: 8]), 32'h00);
    chk("lowcsn_pulses", 32'(pulse_cnt - p0), 32'd0);
    set_tx(8'hC2, 8'h02, 8'h99, 8'h00, 8'h00);
    spi_frame(24, -1);
    chk("lowcsn_next_reg2", 32'(regs[8*2 +: 8]), 32'h99);

    chk("pending_writes", 32'(exp_wr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
